// File: rtl/space_invaders_pkg.sv
// Shared constants, sprite state type and sprite bitmap contents for the
// space invaders display path.
package space_invaders_pkg;

  localparam int ALIEN_WIDTH   = 40;
  localparam int ALIEN_HEIGHT  = 21;
  localparam int ALIEN_GAP     = 10;
  localparam int SCREEN_WIDTH  = 640;
  localparam int SCREEN_HEIGHT = 480;
  localparam int SPRITE_PIXELS = ALIEN_WIDTH * ALIEN_HEIGHT;

  localparam logic [3:0] BACKGROUND_COLOR_NUM = 4'd0;
  localparam logic [3:0] ENEMY_COLOR_NUM      = 4'd3;

  // Bitmap selection for the sprite ROM: the alien artwork, or flat test images.
  localparam int ROM_ALIEN   = 0;
  localparam int ROM_ONES    = 1;
  localparam int ROM_CHECKER = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_LOAD,
    S_SCAN,
    S_DRAIN,
    S_DONE
  } sprite_state_t;

  // Row-major bitmap contents, same layout as the alien .mif image.
  function automatic logic sprite_bit(input int mode, input int addr);
    int   row;
    int   col;
    int   d;
    int   r;
    logic b;
    row = addr / ALIEN_WIDTH;
    col = addr % ALIEN_WIDTH;
    d   = (2 * col > ALIEN_WIDTH - 1) ? 2 * col - (ALIEN_WIDTH - 1) : (ALIEN_WIDTH - 1) - 2 * col;
    r   = (row > ALIEN_HEIGHT / 2) ? row - ALIEN_HEIGHT / 2 : ALIEN_HEIGHT / 2 - row;
    case (mode)
      ROM_ONES:    b = 1'b1;
      ROM_CHECKER: b = ((row + col) % 2) == 0;
      default:     b = (d + 3 * r <= ALIEN_WIDTH) && !(row == 8 && d >= 9 && d <= 15);
    endcase
    if (addr >= SPRITE_PIXELS) b = 1'b0;
    return b;
  endfunction

endpackage

// File: rtl/alien_sprite_rom.sv
// One-bit-wide alien sprite bitmap with a registered read; en low holds the
// last read bit so the draw pipeline can freeze under backpressure.
module alien_sprite_rom
  import space_invaders_pkg::*;
#(
  parameter int ROM_MODE = ROM_ALIEN
) (
  input  logic       clock,
  input  logic       en,
  input  logic [9:0] addr,
  output logic       rd_bit
);

  logic r_bit;

  always_ff @(posedge clock) begin
    if (en) r_bit <= sprite_bit(ROM_MODE, int'(addr));
  end

  assign rd_bit = r_bit;

endmodule

// File: rtl/alien_sprite_drawer.sv
// Rasterizes one alien sprite into the frame-buffer write port, then holds done.
// Handshake: a write transfers on a cycle where pixel_write=1 and pixel_ready=1;
// while pixel_write=1 and pixel_ready=0 the whole pipeline holds and pixel_* stay stable.
module alien_sprite_drawer
  import space_invaders_pkg::*;
#(
  parameter int ROM_MODE = ROM_ALIEN
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [9:0] center_x,
  input  logic [8:0] center_y,
  input  logic [3:0] color,
  input  logic       pixel_ready,
  output logic [9:0] pixel_x,
  output logic [8:0] pixel_y,
  output logic [3:0] pixel_color,
  output logic       pixel_write,
  output logic       done,
  output logic [2:0] dbg_state
);

  localparam logic [5:0]        COL_LAST = 6'(ALIEN_WIDTH - 1);
  localparam logic [4:0]        ROW_LAST = 5'(ALIEN_HEIGHT - 1);
  localparam logic signed [10:0] HALF_W  = 11'(ALIEN_WIDTH / 2);
  localparam logic signed [10:0] HALF_H  = 11'(ALIEN_HEIGHT / 2);
  localparam logic signed [10:0] SCR_W   = 11'(SCREEN_WIDTH);
  localparam logic signed [10:0] SCR_H   = 11'(SCREEN_HEIGHT);

  sprite_state_t r_state;
  sprite_state_t w_state;
  sprite_state_t w_state_next;

  logic [5:0]        r_col;
  logic [4:0]        r_row;
  logic signed [10:0] r_left;
  logic signed [10:0] r_top;
  logic [3:0]        r_color;
  logic              r_erase;
  logic              r_s2_valid;
  logic [5:0]        r_s2_col;
  logic [4:0]        r_s2_row;
  logic [9:0]        r_pix_x;
  logic [8:0]        r_pix_y;
  logic [3:0]        r_pix_color;
  logic              r_pix_write;
  logic              r_done;

  logic              w_stall;
  logic              w_issue;
  logic              w_last;
  logic [9:0]        w_rom_addr;
  logic              w_rom_bit;
  logic signed [10:0] w_cand_x;
  logic signed [10:0] w_cand_y;
  logic              w_on_screen;
  logic              w_cand_write;

  // Reset is the start strobe: the state register parks in S_WAIT so the first
  // cycle after reset falls is already the wait cycle; S_IDLE is reset itself.
  assign w_state    = reset ? S_IDLE : r_state;
  assign w_stall    = r_pix_write & ~pixel_ready;
  assign w_issue    = (w_state == S_SCAN) & ~w_stall;
  assign w_last     = (r_col == COL_LAST) && (r_row == ROW_LAST);
  assign w_rom_addr = 10'(r_row) * 10'(ALIEN_WIDTH) + 10'(r_col);

  alien_sprite_rom #(
    .ROM_MODE(ROM_MODE)
  ) u_rom (
    .clock  (clock),
    .en     (~w_stall),
    .addr   (w_rom_addr),
    .rd_bit (w_rom_bit)
  );

  assign w_cand_x     = r_left + $signed({5'b0, r_s2_col});
  assign w_cand_y     = r_top + $signed({6'b0, r_s2_row});
  assign w_on_screen  = (w_cand_x >= 11'sd0) && (w_cand_x < SCR_W) &&
                        (w_cand_y >= 11'sd0) && (w_cand_y < SCR_H);
  assign w_cand_write = r_s2_valid && w_on_screen && (r_erase || w_rom_bit);

  always_comb begin
    w_state_next = w_state;
    case (w_state)
      S_IDLE:  w_state_next = S_WAIT;
      S_WAIT:  w_state_next = S_LOAD;
      S_LOAD:  w_state_next = S_SCAN;
      S_SCAN:  if (w_issue && w_last) w_state_next = S_DRAIN;
      S_DRAIN: if (!w_stall) w_state_next = S_DONE;
      S_DONE:  w_state_next = S_DONE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= S_WAIT;
      r_col       <= '0;
      r_row       <= '0;
      r_left      <= '0;
      r_top       <= '0;
      r_color     <= '0;
      r_erase     <= 1'b0;
      r_s2_valid  <= 1'b0;
      r_s2_col    <= '0;
      r_s2_row    <= '0;
      r_pix_x     <= '0;
      r_pix_y     <= '0;
      r_pix_color <= '0;
      r_pix_write <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      if (!w_stall) r_state <= w_state_next;
      if (r_state == S_LOAD) begin
        r_left  <= $signed({1'b0, center_x}) - HALF_W;
        r_top   <= $signed({2'b00, center_y}) - HALF_H;
        r_color <= color;
        r_erase <= (color == BACKGROUND_COLOR_NUM);
      end
      if (w_issue) begin
        if (r_col == COL_LAST) begin
          r_col <= '0;
          r_row <= r_row + 5'd1;
        end else begin
          r_col <= r_col + 6'd1;
        end
      end
      if (!w_stall) begin
        r_s2_valid  <= w_issue;
        r_s2_col    <= r_col;
        r_s2_row    <= r_row;
        r_pix_write <= w_cand_write;
        r_done      <= (r_state == S_DONE);
        if (r_s2_valid) begin
          r_pix_x     <= w_cand_x[9:0];
          r_pix_y     <= w_cand_y[8:0];
          r_pix_color <= r_color;
        end
      end
    end
  end

  assign pixel_x     = r_pix_x;
  assign pixel_y     = r_pix_y;
  assign pixel_color = r_pix_color;
  assign pixel_write = r_pix_write;
  assign done        = r_done;
  assign dbg_state   = w_state;

endmodule

// File: tb/tb_alien_sprite_drawer.sv
// Directed bench for alien_sprite_drawer: an all-ones-bitmap instance is
// checked against a geometric pixel model, a checkerboard instance checks erase.
module tb_alien_sprite_drawer;
  import space_invaders_pkg::*;

  logic       clk;
  logic       reset;
  logic [9:0] center_x;
  logic [8:0] center_y;
  logic [3:0] color;
  logic       pixel_ready;

  logic [9:0] pixel_x;
  logic [8:0] pixel_y;
  logic [3:0] pixel_color;
  logic       pixel_write;
  logic       done;
  logic [2:0] dbg_state;

  logic [9:0] chk_x;
  logic [8:0] chk_y;
  logic [3:0] chk_color;
  logic       chk_write;
  logic       chk_done;
  logic [2:0] chk_state;

  alien_sprite_drawer #(.ROM_MODE(ROM_ONES)) u_dut (
    .clock       (clk),
    .reset       (reset),
    .center_x    (center_x),
    .center_y    (center_y),
    .color       (color),
    .pixel_ready (pixel_ready),
    .pixel_x     (pixel_x),
    .pixel_y     (pixel_y),
    .pixel_color (pixel_color),
    .pixel_write (pixel_write),
    .done        (done),
    .dbg_state   (dbg_state)
  );

  alien_sprite_drawer #(.ROM_MODE(ROM_CHECKER)) u_dut_chk (
    .clock       (clk),
    .reset       (reset),
    .center_x    (center_x),
    .center_y    (center_y),
    .color       (color),
    .pixel_ready (pixel_ready),
    .pixel_x     (chk_x),
    .pixel_y     (chk_y),
    .pixel_color (chk_color),
    .pixel_write (chk_write),
    .done        (chk_done),
    .dbg_state   (chk_state)
  );

  // Clock / reset-relative cycle counter
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc;
  always @(posedge clk) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  // Scoreboard state
  logic [22:0] exp_q[$];
  logic [22:0] obs_q[$];
  int n_tests;
  int n_fail;
  int done_seen;
  int done_cyc;
  int first_cyc;
  int overlap_cnt;
  int chk_cnt;
  int chk_nonzero;

  // Accepted-write monitor, sampled on the falling edge
  always @(negedge clk) begin
    if (!reset) begin
      if (pixel_write && pixel_ready) begin
        if (obs_q.size() == 0) first_cyc = cyc;
        obs_q.push_back({pixel_x, pixel_y, pixel_color});
      end
      if (pixel_write && done) overlap_cnt++;
      if (done && done_seen == 0) begin
        done_seen = 1;
        done_cyc  = cyc;
      end
      if (chk_write && pixel_ready) begin
        chk_cnt++;
        if (chk_color != 4'd0) chk_nonzero++;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Driver: pulse reset (the start strobe) with new sprite inputs; returns in cycle 0
  task automatic start_draw(input int cx, input int cy, input int col);
    @(posedge clk);
    #1;
    reset    = 1'b1;
    center_x = 10'(cx);
    center_y = 9'(cy);
    color    = 4'(col);
    obs_q.delete();
    done_seen   = 0;
    done_cyc    = -1;
    first_cyc   = -1;
    overlap_cnt = 0;
    chk_cnt     = 0;
    chk_nonzero = 0;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // Model: every on-screen pixel of the bounding box, row-major
  task automatic build_exp(input int cx, input int cy, input int col);
    int x;
    int y;
    logic [9:0] xv;
    logic [8:0] yv;
    exp_q.delete();
    for (int r = 0; r < ALIEN_HEIGHT; r++) begin
      for (int c = 0; c < ALIEN_WIDTH; c++) begin
        x = cx - 20 + c;
        y = cy - 10 + r;
        if (x >= 0 && x < 640 && y >= 0 && y < 480) begin
          xv = 10'(x);
          yv = 9'(y);
          exp_q.push_back({xv, yv, 4'(col)});
        end
      end
    end
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (done_seen == 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    check({tag, "_done_seen"}, done_seen, 1);
  endtask

  task automatic check_stream(input string tag);
    int n_bad;
    int n;
    n_bad = 0;
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      if (obs_q[i] !== exp_q[i]) n_bad++;
    end
    check({tag, "_count"}, obs_q.size(), exp_q.size());
    check({tag, "_stream_bad"}, n_bad, 0);
    check({tag, "_overlap"}, overlap_cnt, 0);
  endtask

  int         n_bad_hold;
  logic [9:0] fx;
  logic [8:0] fy;
  logic       fw;
  int         n_frozen_bad;

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset       = 1'b1;
    center_x    = '0;
    center_y    = '0;
    color       = '0;
    pixel_ready = 1'b1;
    done_seen   = 0;
    done_cyc    = -1;
    first_cyc   = -1;
    overlap_cnt = 0;
    chk_cnt     = 0;
    chk_nonzero = 0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_pixel_write", pixel_write, 0);
    check("rst_done", done, 0);
    check("rst_pixel_x", pixel_x, 0);
    check("rst_pixel_color", pixel_color, 0);
    check("rst_state", dbg_state, S_IDLE);

    // Centered sprite, enemy color
    build_exp(320, 105, 3);
    start_draw(320, 105, 3);
    wait_done("t1");
    check("t1_done_cycle", done_cyc, 844);
    check("t1_first_cycle", first_cyc, 4);
    check("t1_first_pixel", obs_q[0], {10'd300, 9'd95, 4'd3});
    check("t1_last_pixel", obs_q[obs_q.size() - 1], {10'd339, 9'd115, 4'd3});
    check_stream("t1");
    check("t1_chk_writes", chk_cnt, 420);

    // Done holds with reset low
    n_bad_hold = 0;
    repeat (50) begin
      @(negedge clk);
      if (done !== 1'b1 || pixel_write !== 1'b0) n_bad_hold++;
    end
    check("hold_done_bad", n_bad_hold, 0);

    // Erase writes the full box in background color regardless of bitmap
    build_exp(320, 105, 0);
    start_draw(320, 105, 0);
    wait_done("t2");
    check("t2_done_cycle", done_cyc, 844);
    check_stream("t2");
    check("t2_chk_writes", chk_cnt, 840);
    check("t2_chk_nonzero", chk_nonzero, 0);

    // Clipped at the top-left corner
    build_exp(10, 5, 3);
    start_draw(10, 5, 3);
    wait_done("t3");
    check("t3_done_cycle", done_cyc, 844);
    check("t3_writes", obs_q.size(), 480);
    check("t3_first_pixel", obs_q[0], {10'd0, 9'd0, 4'd3});
    check("t3_last_pixel", obs_q[obs_q.size() - 1], {10'd29, 9'd15, 4'd3});
    check_stream("t3");

    // Backpressure on the third write (cycle 6) for five cycles
    build_exp(320, 105, 3);
    start_draw(320, 105, 3);
    repeat (6) @(posedge clk);
    #1;
    pixel_ready = 1'b0;
    @(negedge clk);
    fx = pixel_x;
    fy = pixel_y;
    fw = pixel_write;
    check("t4_stall_write", fw, 1);
    check("t4_stall_x", fx, 302);
    check("t4_stall_y", fy, 95);
    n_frozen_bad = 0;
    repeat (4) begin
      @(negedge clk);
      if (pixel_x !== fx || pixel_y !== fy || pixel_write !== 1'b1) n_frozen_bad++;
    end
    check("t4_frozen_bad", n_frozen_bad, 0);
    @(posedge clk);
    #1;
    pixel_ready = 1'b1;
    wait_done("t4");
    check("t4_done_cycle", done_cyc, 849);
    check_stream("t4");

    // Abort mid-draw, then restart at a new center
    start_draw(320, 105, 3);
    repeat (200) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    check("t5_abort_write", pixel_write, 0);
    check("t5_abort_done", done, 0);
    build_exp(400, 110, 3);
    start_draw(400, 110, 3);
    wait_done("t5");
    check("t5_done_cycle", done_cyc, 844);
    check("t5_first_pixel", obs_q[0], {10'd380, 9'd100, 4'd3});
    check_stream("t5");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
